// File: rtl/linear_solver_seq.sv
// linear_solver_seq
//   Sequencer in front of the linear_solver datapath. It buffers four satellite
//   measurements over a valid/ready handshake. It then holds the solver enabled
//   with frozen operands until solver_done, or until a timeout expires. On
//   success it publishes the result as a one-cycle fix strobe. An abort input
//   flushes the sequencer back to collection at any time.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   meas_valid / meas_ready      measurement handshake (ready is a register decode)
//   meas_x/y/z/r   [DW-1:0]      measurement fields
//   abort                        synchronous flush request
//   sv_x/y/z/r     [4*DW-1:0]    buffered operands, slot k at [k*DW +: DW]
//   solver_en                    high while waiting for the solver
//   solver_done, c1..c3          solver result handshake and result words
//   fix_x/y/z      [DW-1:0]      last good fix
//   fix_valid / fix_error        one-cycle success / timeout strobes
//   fix_count      [7:0]         good fixes, wraps 255 -> 0
//   state          [1:0]         0=COLLECT 1=WAIT 2=DONE 3=ERR
//   slots          [2:0]         measurements buffered (0..4)
module linear_solver_seq #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64   // legal range 1..255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            meas_valid,
  output logic            meas_ready,
  input  logic [DW-1:0]   meas_x,
  input  logic [DW-1:0]   meas_y,
  input  logic [DW-1:0]   meas_z,
  input  logic [DW-1:0]   meas_r,
  input  logic            abort,
  output logic [4*DW-1:0] sv_x,
  output logic [4*DW-1:0] sv_y,
  output logic [4*DW-1:0] sv_z,
  output logic [4*DW-1:0] sv_r,
  output logic            solver_en,
  input  logic            solver_done,
  input  logic [DW-1:0]   c1,
  input  logic [DW-1:0]   c2,
  input  logic [DW-1:0]   c3,
  output logic [DW-1:0]   fix_x,
  output logic [DW-1:0]   fix_y,
  output logic [DW-1:0]   fix_z,
  output logic            fix_valid,
  output logic            fix_error,
  output logic [7:0]      fix_count,
  output logic [1:0]      state,
  output logic [2:0]      slots
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [2:0]      slots_q, slots_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4*DW-1:0] sv_x_q, sv_x_d, sv_y_q, sv_y_d, sv_z_q, sv_z_d, sv_r_q, sv_r_d;
  logic [DW-1:0]   fix_x_q, fix_x_d, fix_y_q, fix_y_d, fix_z_q, fix_z_d;
  logic [7:0]      fix_count_q, fix_count_d;
  logic            fix_valid_q, fix_valid_d;
  logic            fix_error_q, fix_error_d;
  logic            solver_en_q, solver_en_d;
  logic            accept;

  assign meas_ready = (state_q == ST_COLLECT) && (slots_q < 3'd4);
  assign accept     = meas_valid && meas_ready;

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    slots_d     = slots_q;
    cnt_d       = cnt_q;
    sv_x_d      = sv_x_q;
    sv_y_d      = sv_y_q;
    sv_z_d      = sv_z_q;
    sv_r_d      = sv_r_q;
    fix_x_d     = fix_x_q;
    fix_y_d     = fix_y_q;
    fix_z_d     = fix_z_q;
    fix_count_d = fix_count_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            if (slots_q == 3'(k)) begin
              sv_x_d[k*DW +: DW] = meas_x;
              sv_y_d[k*DW +: DW] = meas_y;
              sv_z_d[k*DW +: DW] = meas_z;
              sv_r_d[k*DW +: DW] = meas_r;
            end
          end
          slots_d = slots_q + 3'd1;
          if (slots_q == 3'd3) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        // A result arriving on the timeout edge still counts as a good fix.
        if (solver_done) begin
          fix_x_d     = c1;
          fix_y_d     = c2;
          fix_z_d     = c3;
          fix_count_d = fix_count_q + 8'd1;
          slots_d     = '0;
          state_d     = ST_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          slots_d = '0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE,
      ST_ERR: state_d = ST_COLLECT;
      default: state_d = ST_COLLECT;
    endcase

    // Abort wins over everything above, including a simultaneous accept.
    if (abort) begin
      state_d     = ST_COLLECT;
      slots_d     = '0;
      sv_x_d      = sv_x_q;
      sv_y_d      = sv_y_q;
      sv_z_d      = sv_z_q;
      sv_r_d      = sv_r_q;
      fix_x_d     = fix_x_q;
      fix_y_d     = fix_y_q;
      fix_z_d     = fix_z_q;
      fix_count_d = fix_count_q;
    end

    // Strobes and enable are registered copies of the next-state decode.
    solver_en_d = (state_d == ST_WAIT);
    fix_valid_d = (state_d == ST_DONE);
    fix_error_d = (state_d == ST_ERR);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values. The operand buffer is reset too, because sv_* are
  // architectural outputs that must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      slots_q     <= '0;
      cnt_q       <= '0;
      sv_x_q      <= '0;
      sv_y_q      <= '0;
      sv_z_q      <= '0;
      sv_r_q      <= '0;
      fix_x_q     <= '0;
      fix_y_q     <= '0;
      fix_z_q     <= '0;
      fix_count_q <= '0;
      fix_valid_q <= 1'b0;
      fix_error_q <= 1'b0;
      solver_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      cnt_q       <= cnt_d;
      sv_x_q      <= sv_x_d;
      sv_y_q      <= sv_y_d;
      sv_z_q      <= sv_z_d;
      sv_r_q      <= sv_r_d;
      fix_x_q     <= fix_x_d;
      fix_y_q     <= fix_y_d;
      fix_z_q     <= fix_z_d;
      fix_count_q <= fix_count_d;
      fix_valid_q <= fix_valid_d;
      fix_error_q <= fix_error_d;
      solver_en_q <= solver_en_d;
    end
  end

  assign sv_x      = sv_x_q;
  assign sv_y      = sv_y_q;
  assign sv_z      = sv_z_q;
  assign sv_r      = sv_r_q;
  assign solver_en = solver_en_q;
  assign fix_x     = fix_x_q;
  assign fix_y     = fix_y_q;
  assign fix_z     = fix_z_q;
  assign fix_valid = fix_valid_q;
  assign fix_error = fix_error_q;
  assign fix_count = fix_count_q;
  assign state     = state_q;
  assign slots     = slots_q;

endmodule

// File: tb/tb_linear_solver_seq.sv
// Testbench for linear_solver_seq: directed stimulus. A behavioural reference
// model is compared against the DUT on every falling edge, and hand-computed
// literal checks pin the model at key points.
module tb_linear_solver_seq;

  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            meas_valid = 1'b0;
  logic            meas_ready;
  logic [DW-1:0]   meas_x = '0, meas_y = '0, meas_z = '0, meas_r = '0;
  logic            abort = 1'b0;
  logic [4*DW-1:0] sv_x, sv_y, sv_z, sv_r;
  logic            solver_en;
  logic            solver_done = 1'b0;
  logic [DW-1:0]   c1 = '0, c2 = '0, c3 = '0;
  logic [DW-1:0]   fix_x, fix_y, fix_z;
  logic            fix_valid, fix_error;
  logic [7:0]      fix_count;
  logic [1:0]      state;
  logic [2:0]      slots;

  int n_total = 0;
  int n_pass  = 0;

  linear_solver_seq #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_x(meas_x), .meas_y(meas_y), .meas_z(meas_z), .meas_r(meas_r),
    .abort(abort),
    .sv_x(sv_x), .sv_y(sv_y), .sv_z(sv_z), .sv_r(sv_r),
    .solver_en(solver_en), .solver_done(solver_done),
    .c1(c1), .c2(c2), .c3(c3),
    .fix_x(fix_x), .fix_y(fix_y), .fix_z(fix_z),
    .fix_valid(fix_valid), .fix_error(fix_error),
    .fix_count(fix_count), .state(state), .slots(slots)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 collecting, 1 waiting for the solver, 2 fix published, 3 timed out.
  typedef struct packed {
    logic [1:0]          phase;
    logic [2:0]          n;
    int                  waited;
    logic [3:0][DW-1:0]  bx, by, bz, br;
    logic [DW-1:0]       fx, fy, fz;
    logic [7:0]          good;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur);
    model_t nx = cur;
    if (abort) begin
      nx.phase = 0;
      nx.n     = 0;
      return nx;
    end
    case (cur.phase)
      2'd0: if (meas_valid && cur.n < 4) begin
        nx.bx[cur.n] = meas_x;
        nx.by[cur.n] = meas_y;
        nx.bz[cur.n] = meas_z;
        nx.br[cur.n] = meas_r;
        nx.n = cur.n + 1;
        if (nx.n == 4) begin
          nx.phase  = 1;
          nx.waited = 0;
        end
      end
      2'd1: begin
        nx.waited = cur.waited + 1;
        if (solver_done) begin
          nx.fx = c1; nx.fy = c2; nx.fz = c3;
          nx.good  = cur.good + 8'd1;
          nx.n     = 0;
          nx.phase = 2;
        end else if (nx.waited == TIMEOUT) begin
          nx.n     = 0;
          nx.phase = 3;
        end
      end
      default: nx.phase = 0;
    endcase
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m);
  end

  always @(negedge clk) begin
    check("state",      state,      m.phase);
    check("slots",      slots,      m.n);
    check("meas_ready", meas_ready, (m.phase == 0) && (m.n < 4));
    check("solver_en",  solver_en,  m.phase == 1);
    check("fix_valid",  fix_valid,  m.phase == 2);
    check("fix_error",  fix_error,  m.phase == 3);
    check("fix_x",      fix_x,      m.fx);
    check("fix_y",      fix_y,      m.fy);
    check("fix_z",      fix_z,      m.fz);
    check("fix_count",  fix_count,  m.good);
    check("sv_x",       sv_x,       m.bx);
    check("sv_y",       sv_y,       m.by);
    check("sv_z",       sv_z,       m.bz);
    check("sv_r",       sv_r,       m.br);
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input logic [DW-1:0] x, y, z, r);
    int t = 0;
    meas_valid = 1'b1;
    meas_x = x; meas_y = y; meas_z = z; meas_r = r;
    while (!meas_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 1, 0);
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic send4(input logic [DW-1:0] base);
    for (int k = 0; k < 4; k++)
      send(base + DW'(k), base + DW'(10 + k), base + DW'(20 + k), base + DW'(30 + k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    #12;
    check("rst_state", state, 0);
    check("rst_ready", meas_ready, 1);
    check("rst_en", solver_en, 0);
    check("rst_svx", sv_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Four back-to-back accepts
    send(32'd2088202,  32'd1, 32'd5, 32'd9);
    send(32'd11092568, 32'd2, 32'd6, 32'd10);
    send(32'd35606984, 32'd3, 32'd7, 32'd11);
    send(32'd3966929,  32'd4, 32'd8, 32'd12);
    check("lit_svx", sv_x, {32'd3966929, 32'd35606984, 32'd11092568, 32'd2088202});
    check("lit_en_after4", solver_en, 1);
    check("lit_ready_wait", meas_ready, 0);
    check("lit_slots4", slots, 4);

    // Solver done on the 3rd WAIT cycle
    c1 = 32'd100; c2 = 32'hFFFF_FF38; c3 = 32'd300;
    @(negedge clk); @(negedge clk);
    solver_done = 1'b1;
    @(negedge clk);
    solver_done = 1'b0;
    check("lit_fix_x", fix_x, 32'd100);
    check("lit_fix_y", fix_y, 32'hFFFF_FF38);
    check("lit_fix_z", fix_z, 32'd300);
    check("lit_fix_valid", fix_valid, 1);
    check("lit_fix_count1", fix_count, 1);
    check("lit_en_drop", solver_en, 0);
    check("lit_ready_done", meas_ready, 0);
    @(negedge clk);
    check("lit_valid_one_cycle", fix_valid, 0);
    check("lit_ready_back", meas_ready, 1);

    // Timeout with solver_done held low
    c1 = 32'd777;
    send4(32'd1000);
    cyc = 1;
    while (!fix_error && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("lit_timeout_cycle", cyc, TIMEOUT + 1);
    check("lit_to_fix_x", fix_x, 32'd100);
    check("lit_to_count", fix_count, 1);
    @(negedge clk);
    check("lit_to_state", state, 0);
    check("lit_to_err_once", fix_error, 0);

    // Abort in the same cycle as solver_done
    send4(32'd2000);
    abort = 1'b1; solver_done = 1'b1; c1 = 32'd555;
    @(negedge clk);
    abort = 1'b0; solver_done = 1'b0;
    check("lit_ab_valid", fix_valid, 0);
    check("lit_ab_count", fix_count, 1);
    check("lit_ab_slots", slots, 0);
    check("lit_ab_fix_x", fix_x, 32'd100);
    // Abort beats a simultaneous accept
    send(32'd41, 32'd42, 32'd43, 32'd44);
    meas_valid = 1'b1; meas_x = 32'd51; abort = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0; abort = 1'b0;
    check("lit_ab_accept_slots", slots, 0);

    // Gapped valid, solver_done ignored while collecting
    solver_done = 1'b1;
    meas_valid = 1'b1; meas_x = 32'hA0; meas_y = 32'hA1; meas_z = 32'hA2; meas_r = 32'hA3;
    @(negedge clk);
    meas_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    meas_valid = 1'b1; meas_x = 32'hB0;
    @(negedge clk);
    meas_valid = 1'b0;
    @(negedge clk);
    check("lit_gap_slots", slots, 2);
    check("lit_gap_state", state, 0);
    check("lit_gap_count", fix_count, 1);
    solver_done = 1'b0;
    send(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    send(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    meas_valid = 1'b1; meas_x = 32'hE0;
    @(negedge clk); @(negedge clk);
    meas_valid = 1'b0;
    check("lit_wait_ignore_slots", slots, 4);
    check("lit_wait_ignore_sv", sv_x, {32'hD0, 32'hC0, 32'hB0, 32'hA0});
    c1 = 32'd7; c2 = 32'd8; c3 = 32'd9;
    solver_done = 1'b1;
    @(negedge clk);
    solver_done = 1'b0;
    check("lit_gap_fix_x", fix_x, 32'd7);
    check("lit_gap_count2", fix_count, 2);
    @(negedge clk);

    // Minimum-turnaround fixes until the counter wraps
    for (int i = 0; i < 254; i++) begin
      send4(DW'(i * 4));
      c1 = DW'(i); c2 = DW'(i + 1); c3 = DW'(i + 2);
      solver_done = 1'b1;
      @(negedge clk);
      solver_done = 1'b0;
      @(negedge clk);
    end
    check("lit_wrap", fix_count, 0);
    check("lit_wrap_fix_x", fix_x, 32'd253);
    send4(32'h100);
    c1 = 32'h1234;
    solver_done = 1'b1;
    @(negedge clk);
    solver_done = 1'b0;
    @(negedge clk);
    check("lit_after_wrap", fix_count, 1);

    // Reset in the middle of WAIT
    send4(32'h5000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_state", state, 0);
    check("lit_rst_en", solver_en, 0);
    check("lit_rst_slots", slots, 0);
    check("lit_rst_fix_x", fix_x, 0);
    check("lit_rst_count", fix_count, 0);
    check("lit_rst_svx", sv_x, 0);
    check("lit_rst_ready", meas_ready, 1);
    check("lit_rst_valid", fix_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
